// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the 64-bit ARM pipeline.
// Owns the EX/MEM and MEM/WB pipeline registers and runs LDUR/STUR/LDURB/STURB
// accesses over a req/ack data-memory handshake. While an access is
// outstanding it stalls the upstream pipeline. An access that goes
// unacknowledged for too long is treated as a sticky fault.
// Optional feature macro: MEM_ALIGN_CHECK_EN (fault on misaligned 64-bit access).
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_byte,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_Rd,
  input  logic [63:0] ALU_result,
  input  logic [63:0] ALU_B,
  output logic [4:0]  mem_Rd,
  output logic [63:0] mem_ALU_result,
  output logic        ex_mem_reg_write,
  output logic [4:0]  wb_Rd,
  output logic [63:0] wb_write_data,
  output logic        mem_wb_reg_write,
  output logic        dm_req,
  output logic        dm_we,
  output logic        dm_size,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata,
  output logic        mem_stall,
  output logic        mem_fault
);

  localparam int DATA_W = 64;
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Byte accesses move only the low byte; upper bits are zero.
  function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] v);
    return {{(DATA_W-8){1'b0}}, v[7:0]};
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;

  // EX/MEM register
  logic               em_write_q, em_write_d;
  logic               em_byte_q, em_byte_d;
  logic               em_reg_write_q, em_reg_write_d;
  logic               em_mem_to_reg_q, em_mem_to_reg_d;
  logic [4:0]         em_rd_q, em_rd_d;
  logic [DATA_W-1:0]  em_alu_q, em_alu_d;
  logic [DATA_W-1:0]  em_b_q, em_b_d;

  // MEM/WB register
  logic               wb_reg_write_q, wb_reg_write_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;

  logic in_wait, in_fault, stall, new_op, misalign;

  assign in_wait  = (state_q == S_WAIT);
  assign in_fault = (state_q == S_FAULT);
  assign stall    = (in_wait & ~dm_ack) | in_fault;
  // A memory op entering EX/MEM this edge (only meaningful when not stalled).
  assign new_op   = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = new_op & ~ex_byte & (|ALU_result[2:0]);
`else
  assign misalign = 1'b0;
`endif

  // EX/MEM next value: capture EX when the pipe advances, hold during a stall.
  always_comb begin
    em_write_d      = em_write_q;
    em_byte_d       = em_byte_q;
    em_reg_write_d  = em_reg_write_q;
    em_mem_to_reg_d = em_mem_to_reg_q;
    em_rd_d         = em_rd_q;
    em_alu_d        = em_alu_q;
    em_b_d          = em_b_q;
    if (!stall) begin
      em_write_d      = ex_valid & ex_mem_write;
      em_byte_d       = ex_byte;
      em_reg_write_d  = ex_valid & ex_reg_write;
      em_mem_to_reg_d = ex_valid & ex_mem_to_reg;
      em_rd_d         = ex_Rd;
      em_alu_d        = ALU_result;
      em_b_d          = ALU_B;
    end
  end

  // Access FSM next state and ack-timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (new_op) state_d = misalign ? S_FAULT : S_WAIT;
      end
      S_WAIT: begin
        if (dm_ack) begin
          cnt_d = '0;
          if (new_op) state_d = misalign ? S_FAULT : S_WAIT;
          else        state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB next value: advance with the pipe, otherwise insert a bubble.
  always_comb begin
    wb_reg_write_d = 1'b0;
    wb_rd_d        = '0;
    wb_data_d      = '0;
    if (!stall) begin
      wb_reg_write_d = em_reg_write_q & ~em_write_q;
      wb_rd_d        = em_rd_q;
      if (em_mem_to_reg_q) wb_data_d = em_byte_q ? zext_byte(dm_rdata) : dm_rdata;
      else                 wb_data_d = em_alu_q;
    end
  end

  // State, counter and both pipeline registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      em_write_q      <= 1'b0;
      em_byte_q       <= 1'b0;
      em_reg_write_q  <= 1'b0;
      em_mem_to_reg_q <= 1'b0;
      em_rd_q         <= '0;
      em_alu_q        <= '0;
      em_b_q          <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      em_write_q      <= em_write_d;
      em_byte_q       <= em_byte_d;
      em_reg_write_q  <= em_reg_write_d;
      em_mem_to_reg_q <= em_mem_to_reg_d;
      em_rd_q         <= em_rd_d;
      em_alu_q        <= em_alu_d;
      em_b_q          <= em_b_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
    end
  end

  // Memory request fields are driven only while an access is outstanding.
  assign dm_req   = in_wait;
  assign dm_we    = in_wait & em_write_q;
  assign dm_size  = in_wait & ~em_byte_q;
  assign dm_addr  = in_wait ? em_alu_q : '0;
  assign dm_wdata = in_wait ? (em_byte_q ? zext_byte(em_b_q) : em_b_q) : '0;

  assign mem_stall        = stall;
  assign mem_fault        = in_fault;
  assign mem_Rd           = em_rd_q;
  assign mem_ALU_result   = em_alu_q;
  assign ex_mem_reg_write = em_reg_write_q;
  assign wb_Rd            = wb_rd_q;
  assign wb_write_data    = wb_data_q;
  assign mem_wb_reg_write = wb_reg_write_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage block of the 64-bit ARM pipeline: sits downstream of the EX stage and owns the EX/MEM and MEM/WB pipeline registers. It performs LDUR/STUR/LDURB/STURB accesses over a req/ack data-memory handshake and stalls the pipeline while an access is outstanding. It sources the MEM-stage and WB-stage values used by the forwarding unit, and the register-file write-back data.

## Interface
Parameters:
- ACK_TIMEOUT, 16: number of consecutive cycles `dm_req` may stay high without `dm_ack` before a fault; legal range 2–255.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_byte  in  1  byte access (LDURB/STURB); 0 = 64-bit
- ex_reg_write, ex_mem_to_reg  in  1 each  WB controls
- ex_Rd  in  5  destination register
- ALU_result  in  64  address or ALU result
- ALU_B  in  64  forwarded store data
- mem_Rd  out  5  EX/MEM destination, to forwarding unit
- mem_ALU_result  out  64  EX/MEM ALU result, to forwarding unit
- ex_mem_reg_write  out  1  `ex_valid & reg_write` held in EX/MEM
- wb_Rd  out  5  MEM/WB destination
- wb_write_data  out  64  write-back data
- mem_wb_reg_write  out  1  MEM/WB write enable
- dm_req, dm_we  out  1 each  memory request, write
- dm_size  out  1  0 = byte, 1 = 64-bit
- dm_addr, dm_wdata  out  64 each
- dm_ack  in  1  access complete this cycle
- dm_rdata  in  64  load data, valid with dm_ack
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX inputs
- mem_fault  out  1  sticky access fault

## Operation
- EX/MEM loads from the ex_* inputs when `mem_stall=0`; holds otherwise.
- FSM states:
  - IDLE: EX/MEM holds no memory op.
  - WAIT: memory op outstanding.
  - FAULT: terminal until rst.
- IDLE→WAIT: EX/MEM loads a valid read or write.
- WAIT→IDLE: `dm_ack=1` and no new memory op is loaded.
- WAIT→WAIT: `dm_ack=1` and a new memory op is loaded (back-to-back).
- WAIT→FAULT: timeout.
- dm_req is high in WAIT only:
  - `dm_addr` = EX/MEM address.
  - `dm_we` = write.
  - `dm_size` = !byte.
  - `dm_wdata` = byte ? {56'b0, B[7:0]} : B.
- `mem_stall = (state==WAIT & !dm_ack) | state==FAULT`.
- MEM/WB loads when `mem_stall=0`; otherwise it loads a bubble with `mem_wb_reg_write=0`.
- `wb_write_data`:
  - mem_to_reg=1: load data, zero-extended `dm_rdata[7:0]` for byte loads.
  - mem_to_reg=0: ALU result.
- Stores never assert `mem_wb_reg_write`.
- Timeout counter:
  - Cleared on entry to WAIT and on each ack.
  - Increments each WAIT cycle without ack.
  - When the ACK_TIMEOUT-th consecutive unacked cycle ends, enter FAULT.
- FAULT: `dm_req=0`, `mem_fault=1`, `mem_stall=1`; the op is dropped with no write-back.
- `dm_ack` outside WAIT is ignored.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, both pipeline registers cleared.
- Reset mid-access drops the request at the same edge; the memory model must discard it.
- Non-memory ops: 1 cycle through MEM, no stall.
- Memory op loaded at edge N: dm_req high from cycle N+1.
  - Ack in cycle N+1+k → mem_stall high for exactly k cycles.
  - WB data valid after edge N+2+k.
- Ack in the first WAIT cycle → zero stall.
- `dm_rdata` is sampled only in the ack cycle.
- Forwarding outputs are stable throughout a stall.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A valid 64-bit access with `ALU_result[2:0]!=0` goes from IDLE directly to FAULT the cycle after it is loaded.
  - No dm_req is ever issued for it.
  - Byte accesses are unchecked.
- MEM_ALIGN_CHECK_EN undefined: no alignment check; the address passes through unchanged.

## Test plan
- LDUR X3, addr 0x40, ack 2 cycles after req, rdata 0xDEADBEEF_01234567:
  - mem_stall high exactly 2 cycles.
  - wb_Rd=3, wb_write_data=0xDEADBEEF_01234567, mem_wb_reg_write=1 for one cycle.
- STURB with ALU_B=0x1122334455667788, ack in first cycle:
  - dm_wdata=0x88, dm_size=0, dm_we=1.
  - No stall; mem_wb_reg_write stays 0.
- LDURB, rdata 0xFFFF_FFFF_FFFF_FFA5 → wb_write_data=0x00000000000000A5.
- Back-to-back LDUR then ADD, each acked immediately:
  - Zero stall cycles.
  - mem_ALU_result/mem_Rd track each instruction on consecutive cycles.
- dm_ack never asserted, ACK_TIMEOUT=16:
  - dm_req high 16 cycles, then mem_fault=1, dm_req=0, mem_stall=1 until rst.
  - rst clears all outputs at the next edge.
- With MEM_ALIGN_CHECK_EN, LDUR at address 0x44:
  - dm_req never asserted.
  - mem_fault=1 one cycle after load.
